mem_stage: RTL

Memory-access pipeline stage, directly upstream of the write-back stage. It issues loads and stores to the data-memory port and aligns store data with byte enables. It sign- or zero-extends load data and registers everything write-back consumes (`WB_alu_data`, `WB_ld_data`, `WB_pc`, `WB_wb_sel`, plus destination-register control). A two-state FSM stalls the upstream pipeline for variable-latency memory.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/mem_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access encodings, FSM states,
// and the alignment rule used to suppress illegal requests.
package mem_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {IDLE, WAIT_RSP} state_t;

   // Size comes from funct3[1:0]; any size code other than byte/half is word-sized.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/byte-enable generation and load
// extraction with sign/zero extension.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_off,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_be,
   output logic [XLEN-1:0] st_wdata,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] ld_word,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0]        ld_shift;
   logic signed [7:0]      ld_byte;
   logic signed [15:0]     ld_half;
   logic signed [XLEN-1:0] byte_sx;
   logic signed [XLEN-1:0] half_sx;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3)
         F3_SB: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_SH: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Move the addressed lane down to bit 0 before extension.
   assign ld_shift = ld_word >> {ld_off, 3'b000};
   assign ld_byte  = ld_shift[7:0];
   assign ld_half  = ld_shift[15:0];
   assign byte_sx  = ld_byte;
   assign half_sx  = ld_half;

   always_comb begin
      ld_data = ld_word;
      case (ld_funct3)
         F3_LB:   ld_data = byte_sx;
         F3_LBU:  ld_data = {24'd0, ld_shift[7:0]};
         F3_LH:   ld_data = half_sx;
         F3_LHU:  ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while a
// request or load response is outstanding, and registers results into WB.
module mem_stage
   import mem_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            MEM_valid,
   input  logic [XLEN-1:0] MEM_alu_data,
   input  logic [XLEN-1:0] MEM_rs2_data,
   input  logic [XLEN-1:0] MEM_pc,
   input  logic [1:0]      MEM_wb_sel,
   input  logic [4:0]      MEM_rd_addr,
   input  logic            MEM_rd_wren,
   input  logic            MEM_mem_rden,
   input  logic            MEM_mem_wren,
   input  logic [2:0]      MEM_funct3,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [XLEN-1:0] o_dmem_wdata,
   output logic [3:0]      o_dmem_be,
   input  logic            i_dmem_ready,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_mem_stall,
   output logic            WB_valid,
   output logic            WB_rd_wren,
   output logic [4:0]      WB_rd_addr,
   output logic [1:0]      WB_wb_sel,
   output logic [XLEN-1:0] WB_alu_data,
   output logic [XLEN-1:0] WB_ld_data,
   output logic [XLEN-1:0] WB_pc,
   output logic            o_misaligned
);

   state_t          state_p0;
   logic [1:0]      ld_off_p1;
   logic [2:0]      ld_funct3_p1;

   logic            mem_op;
   logic            mis;
   logic            in_idle;
   logic            req;
   logic            ld_accept;
   logic            stall;
   logic [3:0]      st_be;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_ext;

   lsu_align u_align (
      .st_funct3 (MEM_funct3),
      .st_off    (MEM_alu_data[1:0]),
      .st_data   (MEM_rs2_data),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (ld_funct3_p1),
      .ld_off    (ld_off_p1),
      .ld_word   (i_dmem_rdata),
      .ld_data   (ld_ext)
   );

   // MEM stage: request issue and stall decision
   assign mem_op    = MEM_valid & (MEM_mem_rden | MEM_mem_wren);
   assign mis       = mem_op & is_misaligned(MEM_funct3, MEM_alu_data[1:0]);
   assign in_idle   = (state_p0 == IDLE);
   assign req       = i_reset & in_idle & mem_op & ~mis;
   assign ld_accept = req & MEM_mem_rden & i_dmem_ready;
   assign stall     = i_reset & (in_idle ? (req & (~i_dmem_ready | MEM_mem_rden))
                                         : ~i_dmem_rvalid);

   assign o_mem_stall  = stall;
   assign o_dmem_req   = req;
   assign o_dmem_we    = req & MEM_mem_wren;
   assign o_dmem_addr  = req ? {MEM_alu_data[XLEN-1:2], 2'b00} : '0;
   assign o_dmem_be    = o_dmem_we ? st_be : 4'b0000;
   assign o_dmem_wdata = o_dmem_we ? st_wdata : '0;

   // Extraction context captured at load acceptance
   always_ff @(posedge i_clk) begin
      if (ld_accept) begin
         ld_off_p1    <= MEM_alu_data[1:0];
         ld_funct3_p1 <= MEM_funct3;
      end
   end

   // WB stage register and FSM
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_p0     <= IDLE;
         WB_valid     <= 1'b0;
         WB_rd_wren   <= 1'b0;
         WB_rd_addr   <= '0;
         WB_wb_sel    <= '0;
         WB_alu_data  <= '0;
         WB_ld_data   <= '0;
         WB_pc        <= '0;
         o_misaligned <= 1'b0;
      end else begin
         case (state_p0)
            IDLE: begin
               if (ld_accept) state_p0 <= WAIT_RSP;
               if (stall) begin
                  WB_valid     <= 1'b0;
                  WB_rd_wren   <= 1'b0;
                  o_misaligned <= 1'b0;
               end else begin
                  WB_valid     <= MEM_valid;
                  WB_rd_wren   <= MEM_valid & MEM_rd_wren & ~mis;
                  WB_rd_addr   <= MEM_rd_addr;
                  WB_wb_sel    <= MEM_wb_sel;
                  WB_alu_data  <= MEM_alu_data;
                  WB_pc        <= MEM_pc;
                  WB_ld_data   <= '0;
                  o_misaligned <= mis;
               end
            end
            WAIT_RSP: begin
               o_misaligned <= 1'b0;
               if (i_dmem_rvalid) begin
                  state_p0    <= IDLE;
                  WB_valid    <= 1'b1;
                  WB_rd_wren  <= MEM_rd_wren;
                  WB_rd_addr  <= MEM_rd_addr;
                  WB_wb_sel   <= MEM_wb_sel;
                  WB_alu_data <= MEM_alu_data;
                  WB_pc       <= MEM_pc;
                  WB_ld_data  <= ld_ext;
               end else begin
                  WB_valid    <= 1'b0;
                  WB_rd_wren  <= 1'b0;
               end
            end
            default: state_p0 <= IDLE;
         endcase
      end
   end

endmodule
